ps2_kbd_ctrl: RTL and testbench

- Consumer-side controller for the PS/2 keyboard receiver FIFO. It drains bytes using the receiver's ready / active-low nextdata_n pop handshake.
- Parses the scan-code set 2 prefixes 0xE0 (extended) and 0xF0 (break) into single key events, delivered over a valid/ready handshake.
- Tracks the held key, counts make events and flags error conditions.
- Sits between the receiver and the CPU-side keyboard MMIO/event logic.

---
 rtl/ps2_kbd_ctrl.sv | 129 ++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard consumer: pops receiver FIFO bytes, folds E0/F0 prefixes into key events, tracks held key.
// Optional typematic-repeat discard with PS2_KBD_REPEAT_FILTER_EN; ev_valid four cycles after kb_ready.
module ps2_kbd_ctrl #(
   parameter int COUNT_W        = 8,
   parameter int PREFIX_TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         kb_data,
   input  logic               kb_ready,
   input  logic               kb_overflow,
   output logic               kb_nextdata_n,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [7:0]         ev_code,
   output logic               ev_ext,
   output logic               ev_break,
   output logic               held_valid,
   output logic [8:0]         held_code,
   output logic [COUNT_W-1:0] key_count,
   output logic               err,
   input  logic               err_clr
);
   typedef enum logic [2:0] {IDLE, ACK, GAP, DECODE, EMIT} state_t;

   localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

   state_t        state;
   logic [7:0]    byte_r;
   logic          ext_f;
   logic          brk_f;
   logic [TW-1:0] to_cnt;

   logic bad_byte;
   logic is_repeat;
   logic to_hit;
   logic err_set;

   always_comb begin
      bad_byte = (byte_r == 8'h00) || (byte_r == 8'hFF) || (byte_r == 8'hE1);
      // A byte waiting at the FIFO head beats an expiring prefix.
      to_hit   = (state == IDLE) && !kb_ready && (ext_f || brk_f) && (to_cnt == TO_LAST);
`ifdef PS2_KBD_REPEAT_FILTER_EN
      is_repeat = !brk_f && held_valid && ({ext_f, byte_r} == held_code);
`else
      is_repeat = 1'b0;
`endif
      err_set  = kb_overflow || to_hit || ((state == DECODE) && bad_byte);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         byte_r        <= 8'h00;
         ext_f         <= 1'b0;
         brk_f         <= 1'b0;
         to_cnt        <= '0;
         kb_nextdata_n <= 1'b1;
         ev_valid      <= 1'b0;
         ev_code       <= 8'h00;
         ev_ext        <= 1'b0;
         ev_break      <= 1'b0;
         held_valid    <= 1'b0;
         held_code     <= 9'h000;
         key_count     <= '0;
         err           <= 1'b0;
      end else begin
         if (err_set)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;

         case (state)
            IDLE: begin
               if (kb_ready) begin
                  byte_r        <= kb_data;
                  kb_nextdata_n <= 1'b0;
                  to_cnt        <= '0;
                  state         <= ACK;
               end else if (to_hit) begin
                  ext_f  <= 1'b0;
                  brk_f  <= 1'b0;
                  to_cnt <= '0;
               end else if (ext_f || brk_f) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ACK: begin
               kb_nextdata_n <= 1'b1;
               state         <= GAP;
            end
            GAP: state <= DECODE;
            DECODE: begin
               state <= IDLE;
               if (byte_r == 8'hE0) begin
                  ext_f <= 1'b1;
               end else if (byte_r == 8'hF0) begin
                  brk_f <= 1'b1;
               end else begin
                  ext_f <= 1'b0;
                  brk_f <= 1'b0;
                  if (!bad_byte && !is_repeat) begin
                     ev_code  <= byte_r;
                     ev_ext   <= ext_f;
                     ev_break <= brk_f;
                     ev_valid <= 1'b1;
                     state    <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (ev_ready) begin
                  ev_valid <= 1'b0;
                  state    <= IDLE;
                  if (!ev_break) begin
                     key_count  <= key_count + 1'b1;
                     held_valid <= 1'b1;
                     held_code  <= {ev_ext, ev_code};
                  end else if ({ev_ext, ev_code} == held_code) begin
                     held_valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: queue-based receiver model plus a byte-stream event model.
module tb_ps2_kbd_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       kb_nextdata_n;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       held_valid;
   logic [8:0] held_code;
   logic [7:0] key_count;
   logic       err;
   logic       err_clr;

   ps2_kbd_ctrl #(.COUNT_W(8), .PREFIX_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .held_valid(held_valid),
      .held_code(held_code), .key_count(key_count), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         pops = 0;
   int         ev_seen = 0;
   bit         prev_low = 1'b0;
   logic [7:0] rxq[$];
   logic [9:0] exp_q[$];
   bit         m_ext, m_brk, m_held_v, m_err;
   logic [8:0] m_held;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scan-code set 2 rules applied to one byte, in stream order.
   task automatic model_byte(input logic [7:0] b);
      bit rep;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
         m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else begin
         rep = 1'b0;
`ifdef PS2_KBD_REPEAT_FILTER_EN
         rep = !m_brk && m_held_v && ({m_ext, b} == m_held);
`endif
         if (!rep) begin
            exp_q.push_back({m_ext, m_brk, b});
            if (!m_brk) begin
               m_cnt++; m_held_v = 1'b1; m_held = {m_ext, b};
            end else if ({m_ext, b} == m_held) begin
               m_held_v = 1'b0;
            end
         end
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_held_v = 0; m_err = 0; m_held = 9'h0; m_cnt = 0;
      exp_q.delete(); rxq.delete();
   endtask

   task automatic send(input logic [7:0] b);
      rxq.push_back(b);
      model_byte(b);
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   // Receiver FIFO model and event monitor, both away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (kb_nextdata_n == 1'b0) begin
            pops++;
            chk("pop_width", prev_low, 1'b0);
            chk("pop_nonempty", rxq.size() != 0, 1'b1);
            if (rxq.size() != 0) void'(rxq.pop_front());
         end
         prev_low = !kb_nextdata_n;
         if (ev_valid && ev_ready) begin
            ev_seen++;
            chk("ev_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("ev_fields", {ev_ext, ev_break, ev_code}, exp_q.pop_front());
         end
      end
      kb_ready = (rxq.size() != 0);
      kb_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
   end

   task automatic wait_drain(input bit rnd);
      int i;
      for (i = 0; i < 3000; i++) begin
         step();
         ev_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rxq.size() == 0 && exp_q.size() == 0) break;
      end
      chk("drain_budget", i < 3000, 1'b1);
      ev_ready = 1'b1;
      repeat (6) step();
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"}, key_count, m_cnt[7:0]);
      chk({tag, "_held_v"}, held_valid, m_held_v);
      chk({tag, "_held"}, held_code, m_held);
      chk({tag, "_err"}, err, m_err);
   endtask

   task automatic err_pulse_clear();
      step(); err_clr = 1'b1;
      step(); err_clr = 1'b0;
      @(negedge clk);
      chk("err_clear", err, 1'b0);
      m_err = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int i, p0, e0, exp_n, len;
      logic [7:0] b;
      logic [7:0] bad_tab[3];
      logic [7:0] key_tab[4];
      bad_tab = '{8'h00, 8'hFF, 8'hE1};
      key_tab = '{8'h1C, 8'h75, 8'h6B, 8'h1C};

      rst = 1'b1; kb_overflow = 0; err_clr = 0; ev_ready = 1'b1;
      kb_ready = 0; kb_data = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_nextdata_n", kb_nextdata_n, 1'b1);
      chk("rst_ev_valid", ev_valid, 1'b0);
      chk("rst_ev_fields", {ev_ext, ev_break, ev_code}, 10'h0);
      check_state("rst");

      // Single make: one-cycle pop strobe, four-cycle latency
      step(); send(8'h1C);
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 1) chk("lat_pop_low", kb_nextdata_n, 1'b0);
         if (i == 2) chk("lat_pop_high", kb_nextdata_n, 1'b1);
         if (ev_valid) break;
      end
      chk("latency", i, 4);
      wait_drain(0);
      check_state("make1c");
      chk("make1c_held_lit", held_code, 9'h01C);

      p0 = pops; send(8'hF0); send(8'h1C); wait_drain(0);
      chk("brk_pops", pops - p0, 2);
      check_state("brk1c");

      p0 = pops; send(8'hE0); send(8'hF0); send(8'h75); wait_drain(0);
      chk("extbrk_pops", pops - p0, 3);
      check_state("extbrk");
      send(8'hE0); send(8'h75); wait_drain(0);
      check_state("ext75");
      chk("ext75_held_lit", held_code, 9'h175);

      // Consumer stall: no pops while an event waits
      ev_ready = 1'b0; send(8'h1C);
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ev_valid) break;
      end
      chk("stall_valid", ev_valid, 1'b1);
      step(); p0 = pops;
      send(8'h21); send(8'h22); send(8'h23);
      repeat (50) step();
      @(negedge clk);
      chk("stall_pops", pops - p0, 0);
      chk("stall_code", {ev_valid, ev_code}, {1'b1, 8'h1C});
      chk("stall_fifo", rxq.size(), 3);
      wait_drain(0);
      check_state("stall");

      // Prefix timeout then an unprefixed key
      step(); send(8'hE0);
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (err) break;
      end
      chk("timeout_cycle", i, 20);
      m_ext = 1'b0; m_brk = 1'b0; m_err = 1'b1;
      step(); send(8'h1C); wait_drain(0);
      check_state("timeout");
      err_pulse_clear();

      step(); kb_overflow = 1'b1;
      step(); kb_overflow = 1'b0;
      @(negedge clk);
      chk("overflow_err", err, 1'b1);
      err_pulse_clear();
      step(); kb_overflow = 1'b1; err_clr = 1'b1;
      step(); kb_overflow = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      chk("set_wins", err, 1'b1);
      err_pulse_clear();

      // Typematic repeats
      send(8'h33); wait_drain(0);
      e0 = ev_seen;
      send(8'h1C); send(8'h1C); send(8'h1C); wait_drain(0);
`ifdef PS2_KBD_REPEAT_FILTER_EN
      exp_n = 1;
`else
      exp_n = 3;
`endif
      chk("typematic_events", ev_seen - e0, exp_n);
      check_state("typematic");

      // Random bursts with random consumer back-pressure
      for (int k = 0; k < 30; k++) begin
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            case ($urandom_range(0, 9))
               0, 1:    b = 8'hE0;
               2, 3:    b = 8'hF0;
               4:       b = bad_tab[$urandom_range(0, 2)];
               5, 6:    b = key_tab[$urandom_range(0, 3)];
               default: b = 8'($urandom_range(1, 8'hDF));
            endcase
            send(b);
         end
         send(key_tab[$urandom_range(0, 3)]);
         wait_drain(1);
         check_state("rand");
         if (m_err) err_pulse_clear();
      end

      // Reset while an event is pending
      ev_ready = 1'b0; send(8'h5A);
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ev_valid) break;
      end
      chk("pre_rst_valid", ev_valid, 1'b1);
      step(); rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_valid", ev_valid, 1'b0);
      chk("mid_rst_fields", {ev_ext, ev_break, ev_code}, 10'h0);
      chk("mid_rst_nextdata_n", kb_nextdata_n, 1'b1);
      check_state("mid_rst");
      step(); rst = 1'b0; ev_ready = 1'b1;
      send(8'h1C); wait_drain(0);
      check_state("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
